// File: rtl/imem_loader.sv
// imem_loader: program loader for a 16-bit instruction memory.
//
// Consumes a byte image from a host link (count byte N, then 2N data bytes,
// each word high byte first) and writes one 16-bit word per pair of bytes to
// consecutive word addresses starting at 0. The CPU is held in stall while a
// load is in progress and after a malformed image.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a trailing byte equal to the modulo-256 sum of the count
//   byte and all data bytes is expected after the last word; a mismatch
//   aborts the load into the error state.
//
// Handshake: a byte transfers on a rising edge where in_valid & in_ready are
// both high; in_ready depends only on the current state (never on in_valid),
// so the host may hold or drop in_valid freely and in_data is ignored on any
// cycle without a transfer.
//
// Memory write port: mem_addr, mem_wr_data and mem_wr_en are registered and
// are loaded together on the edge that accepts a word's low byte, so the
// address and data are stable for the whole single-cycle write strobe. The
// address and data registers hold their last values between writes.

module imem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [15:0]       mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_stall
);

  // Word index must be able to hold N itself (up to DEPTH) for the
  // end-of-image compare.
  localparam int IDX_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [IDX_W-1:0] idx;       // index of the word currently being assembled
  logic [IDX_W-1:0] idx_inc;   // idx + 1, the index after this word's write
  logic [IDX_W-1:0] n_q;       // latched word count N of the current image
  logic [7:0]       hi_q;      // high byte of the word being assembled
  logic             xfer;      // a byte transfers on the coming edge
  logic             count_bad; // count byte is 0 or exceeds DEPTH
  logic             last_word; // the word in WRITE is the image's last one

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       sum_q;     // running modulo-256 sum of count and data bytes
`endif

  assign xfer      = in_valid & in_ready;
  assign idx_inc   = idx + IDX_W'(1);
  assign last_word = (idx_inc == n_q);
  assign count_bad = (in_data == 8'd0) || ({24'd0, in_data} > 32'(DEPTH));

  // Status flags are pure functions of the state: DONE and ERR are only
  // left on start or reset, which gives the sticky behaviour for free.
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);
  assign cpu_stall = busy | error;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, byte-accept and busy decode. The byte-accepting states use
  // in_valid directly since in_ready is 1 in each of them, keeping in_ready
  // free of any path from in_valid.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          state_nxt = count_bad ? S_ERR : S_HI;
        end
      end
      S_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          state_nxt = S_LO;
        end
      end
      S_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // The write strobe is high during this cycle; no byte is taken so
        // the next high byte cannot overtake the word being written.
        busy = 1'b1;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_HI;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          state_nxt = (in_data == sum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: word index, count latch, byte assembly and the registered
  // memory write port. A new load clears the index (and checksum) but not
  // the memory port registers, which keep their last written values.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx         <= '0;
      n_q         <= '0;
      hi_q        <= 8'd0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 16'd0;
    end else begin
      mem_wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            idx <= '0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            // A bad count is discarded with the jump to ERR, so truncation
            // here only ever drops bits of an out-of-range value.
            n_q <= IDX_W'(in_data);
          end
        end
        S_HI: begin
          if (xfer) begin
            hi_q <= in_data;
          end
        end
        S_LO: begin
          if (xfer) begin
            mem_wr_en   <= 1'b1;
            mem_addr    <= ADDR_W'(idx);
            mem_wr_data <= {hi_q, in_data};
          end
        end
        S_WRITE: begin
          idx <= idx_inc;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Checksum accumulator: sums the count byte and every data byte accepted
  // in this load; cleared when a new load starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            sum_q <= 8'd0;
          end
        end
        S_LEN, S_HI, S_LO: begin
          if (xfer) begin
            sum_q <= sum_q + in_data;
          end
        end
        default: begin
        end
      endcase
    end
  end
`endif

endmodule
